// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the MIPS31 PC fetch sequencer.
// Holds the FSM state encoding, the next-PC select codes and the alignment helper.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_EXEC   = 2'd1,
      ST_HALTED = 2'd2,
      ST_FAULT  = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      SEL_SEQ = 3'd0,
      SEL_BR  = 3'd1,
      SEL_JMP = 3'd2,
      SEL_JR  = 3'd3,
      SEL_EXC = 3'd4
   } pc_sel_e;

   localparam logic [31:0] PC_STEP = 32'd4;

   // Instruction addresses must be word aligned.
   function automatic logic is_misaligned(input logic [31:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selector: exception > jr > jmp > branch > sequential.
// A misaligned redirect target is turned into an exception to the vector.
module pc_next_mux
   import pc_seq_pkg::*;
(
   input  logic [31:0] pc,
   input  logic        exc,
   input  logic        jr,
   input  logic [31:0] jr_target,
   input  logic        jmp,
   input  logic [31:0] jmp_target,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic [31:0] exc_vector,
   output logic [31:0] next_pc,
   output logic        take_exc,
   output logic        misalign
);

   pc_sel_e     sel_s;
   logic [31:0] target_s;
   logic        redirect_s;
   logic        misalign_s;

   // Priority selection of the candidate next PC.
   always_comb begin
      sel_s    = SEL_SEQ;
      target_s = pc + PC_STEP;
      if (exc) begin
         sel_s    = SEL_EXC;
         target_s = exc_vector;
      end else if (jr) begin
         sel_s    = SEL_JR;
         target_s = jr_target;
      end else if (jmp) begin
         sel_s    = SEL_JMP;
         target_s = jmp_target;
      end else if (br_taken) begin
         sel_s    = SEL_BR;
         target_s = br_target;
      end else begin
         sel_s    = SEL_SEQ;
         target_s = pc + PC_STEP;
      end
   end

   // Alignment check on redirects only; the vector itself is trusted.
   always_comb begin
      redirect_s = 1'b0;
      case (sel_s)
         SEL_JR, SEL_JMP, SEL_BR: redirect_s = 1'b1;
         default:                 redirect_s = 1'b0;
      endcase
      misalign_s = redirect_s & is_misaligned(target_s);
      take_exc   = (sel_s == SEL_EXC) | misalign_s;
      misalign   = misalign_s;
      if (take_exc) begin
         next_pc = exc_vector;
      end else begin
         next_pc = target_s;
      end
   end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter sequencer for the multicycle MIPS31 core: fetch, wait for
// ack, present the instruction, then update PC/EPC with single-cycle write pulses.
module pc_fetch_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC      = 32'h0040_0000,
   parameter logic [31:0] EXC_VECTOR    = 32'h0040_0004,
   parameter int unsigned FETCH_TIMEOUT = 16
)
(
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr_out,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jmp,
   input  logic [31:0] jmp_target,
   input  logic        jr,
   input  logic [31:0] jr_target,
   input  logic        exc,
   input  logic        halt,
   output logic [31:0] pc_out,
   output logic        pc_we,
   output logic [31:0] epc_out,
   output logic        epc_we,
   output logic        fetch_err,
   output logic        misalign
);

   localparam logic [7:0] CNT_LAST = 8'(FETCH_TIMEOUT - 1);

   state_e      state_r, state_nxt_s;
   logic [31:0] pc_r, pc_nxt_s;
   logic [31:0] instr_r, instr_nxt_s;
   logic [31:0] epc_r, epc_nxt_s;
   logic [7:0]  cnt_r, cnt_nxt_s;
   logic        pc_we_r, pc_we_nxt_s;
   logic        epc_we_r, epc_we_nxt_s;
   logic        misalign_r, misalign_nxt_s;
   logic        fetch_err_r, fetch_err_nxt_s;

   logic [31:0] mux_next_pc_s;
   logic        mux_take_exc_s;
   logic        mux_misalign_s;

   pc_next_mux u_pc_next_mux (
      .pc         (pc_r),
      .exc        (exc),
      .jr         (jr),
      .jr_target  (jr_target),
      .jmp        (jmp),
      .jmp_target (jmp_target),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .exc_vector (EXC_VECTOR),
      .next_pc    (mux_next_pc_s),
      .take_exc   (mux_take_exc_s),
      .misalign   (mux_misalign_s)
   );

   // Next-state and next-register computation.
   always_comb begin
      state_nxt_s     = state_r;
      pc_nxt_s        = pc_r;
      instr_nxt_s     = instr_r;
      epc_nxt_s       = epc_r;
      cnt_nxt_s       = cnt_r;
      pc_we_nxt_s     = 1'b0;
      epc_we_nxt_s    = 1'b0;
      misalign_nxt_s  = 1'b0;
      fetch_err_nxt_s = fetch_err_r;
      case (state_r)
         ST_FETCH: begin
            if (imem_ack) begin
               instr_nxt_s = imem_rdata;
               cnt_nxt_s   = 8'd0;
               state_nxt_s = ST_EXEC;
            end else if (cnt_r == CNT_LAST) begin
               state_nxt_s     = ST_FAULT;
               fetch_err_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + 8'd1;
            end
         end
         ST_EXEC: begin
            if (stall) begin
               state_nxt_s = ST_EXEC;
            end else if (halt) begin
               state_nxt_s = ST_HALTED;
            end else begin
               state_nxt_s    = ST_FETCH;
               pc_nxt_s       = mux_next_pc_s;
               pc_we_nxt_s    = 1'b1;
               misalign_nxt_s = mux_misalign_s;
               if (mux_take_exc_s) begin
                  epc_nxt_s    = pc_r;
                  epc_we_nxt_s = 1'b1;
               end else begin
                  epc_nxt_s    = epc_r;
                  epc_we_nxt_s = 1'b0;
               end
            end
         end
         ST_HALTED: begin
            state_nxt_s = ST_HALTED;
         end
         ST_FAULT: begin
            state_nxt_s     = ST_FAULT;
            fetch_err_nxt_s = 1'b1;
         end
         default: begin
            state_nxt_s = ST_FETCH;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_FETCH;
         pc_r        <= RESET_PC;
         instr_r     <= 32'd0;
         epc_r       <= 32'd0;
         cnt_r       <= 8'd0;
         pc_we_r     <= 1'b0;
         epc_we_r    <= 1'b0;
         misalign_r  <= 1'b0;
         fetch_err_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         pc_r        <= pc_nxt_s;
         instr_r     <= instr_nxt_s;
         epc_r       <= epc_nxt_s;
         cnt_r       <= cnt_nxt_s;
         pc_we_r     <= pc_we_nxt_s;
         epc_we_r    <= epc_we_nxt_s;
         misalign_r  <= misalign_nxt_s;
         fetch_err_r <= fetch_err_nxt_s;
      end
   end

   assign imem_req    = (state_r == ST_FETCH);
   assign imem_addr   = pc_r;
   assign instr_valid = (state_r == ST_EXEC);
   assign instr_out   = instr_r;
   assign pc_out      = pc_r;
   assign pc_we       = pc_we_r;
   assign epc_out     = epc_r;
   assign epc_we      = epc_we_r;
   assign fetch_err   = fetch_err_r;
   assign misalign    = misalign_r;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed self-checking bench for pc_fetch_sequencer; inputs change and
// outputs are sampled 1 ns after each rising edge.
module tb_pc_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jmp;
   logic [31:0] jmp_target;
   logic        jr;
   logic [31:0] jr_target;
   logic        exc;
   logic        halt;
   logic [31:0] pc_out;
   logic        pc_we;
   logic [31:0] epc_out;
   logic        epc_we;
   logic        fetch_err;
   logic        misalign;

   int total = 0;
   int bad   = 0;
   int req_cnt, val_cnt, we_cnt;

   always #5 clk = ~clk;

   pc_fetch_sequencer #(
      .RESET_PC      (32'h0040_0000),
      .EXC_VECTOR    (32'h0040_0004),
      .FETCH_TIMEOUT (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_out   (instr_out),
      .stall       (stall),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .jmp         (jmp),
      .jmp_target  (jmp_target),
      .jr          (jr),
      .jr_target   (jr_target),
      .exc         (exc),
      .halt        (halt),
      .pc_out      (pc_out),
      .pc_we       (pc_we),
      .epc_out     (epc_out),
      .epc_we      (epc_we),
      .fetch_err   (fetch_err),
      .misalign    (misalign)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_redirects();
      br_taken   = 1'b0;
      br_target  = 32'd0;
      jmp        = 1'b0;
      jmp_target = 32'd0;
      jr         = 1'b0;
      jr_target  = 32'd0;
      exc        = 1'b0;
      halt       = 1'b0;
      stall      = 1'b0;
   endtask

   // One fetch acked immediately, then EXEC with the current redirect inputs.
   task automatic fetch_exec(input logic [31:0] word);
      imem_ack   = 1'b1;
      imem_rdata = word;
      tick();
      imem_ack   = 1'b0;
      tick();
   endtask

   initial begin
      rst        = 1'b1;
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      clear_redirects();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_pc", pc_out, 32'h0040_0000);
      check("rst_addr", imem_addr, 32'h0040_0000);
      check("rst_req", {31'd0, imem_req}, 32'd1);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_instr", instr_out, 32'd0);
      check("rst_epc", epc_out, 32'd0);
      check("rst_pcwe", {31'd0, pc_we}, 32'd0);
      check("rst_err", {31'd0, fetch_err}, 32'd0);

      // Sequential loop, ack in first FETCH cycle
      imem_ack   = 1'b1;
      imem_rdata = 32'h1111_0001;
      tick();
      imem_ack = 1'b0;
      check("t1_valid", {31'd0, instr_valid}, 32'd1);
      check("t1_req_exec", {31'd0, imem_req}, 32'd0);
      check("t1_instr", instr_out, 32'h1111_0001);
      check("t1_pcwe_exec", {31'd0, pc_we}, 32'd0);
      tick();
      check("t1_pc4", pc_out, 32'h0040_0004);
      check("t1_pcwe4", {31'd0, pc_we}, 32'd1);
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      check("t1_pcwe_gap", {31'd0, pc_we}, 32'd0);
      tick();
      check("t1_pc8", pc_out, 32'h0040_0008);
      check("t1_pcwe8", {31'd0, pc_we}, 32'd1);

      // Delayed ack and stalled EXEC; halt during stall must be ignored
      req_cnt = 0;
      val_cnt = 0;
      we_cnt  = 0;
      imem_rdata = 32'hCAFE_0002;
      for (int i = 0; i < 8; i++) begin
         if (i <= 6) begin
            req_cnt += int'(imem_req);
            val_cnt += int'(instr_valid);
         end
         if (i >= 1) we_cnt += int'(pc_we);
         if (instr_valid) check("t2_instr", instr_out, 32'hCAFE_0002);
         if (i < 7) begin
            imem_ack = (i == 3);
            stall    = (i == 4 || i == 5);
            halt     = (i == 4 || i == 5);
            tick();
         end
      end
      clear_redirects();
      imem_ack = 1'b0;
      check("t2_req_cnt", req_cnt, 32'd4);
      check("t2_val_cnt", val_cnt, 32'd3);
      check("t2_we_cnt", we_cnt, 32'd1);
      check("t2_pc", pc_out, 32'h0040_000C);

      // Priority jr > jmp > br at 0x00400010
      fetch_exec(32'h0);
      check("t3_pc10", pc_out, 32'h0040_0010);
      br_taken = 1'b1; br_target = 32'h0040_0100;
      jmp = 1'b1;      jmp_target = 32'h0040_0200;
      jr = 1'b1;       jr_target = 32'h0040_0300;
      fetch_exec(32'h0);
      check("t3_jr", pc_out, 32'h0040_0300);
      check("t3_jr_epcwe", {31'd0, epc_we}, 32'd0);
      check("t3_jr_mis", {31'd0, misalign}, 32'd0);
      jr = 1'b0;
      fetch_exec(32'h0);
      check("t3_jmp", pc_out, 32'h0040_0200);
      clear_redirects();
      br_taken = 1'b1; br_target = 32'h0040_0020;
      fetch_exec(32'h0);
      check("t3_br", pc_out, 32'h0040_0020);
      clear_redirects();

      // Misaligned jump becomes an exception
      jmp = 1'b1; jmp_target = 32'h0040_0102;
      fetch_exec(32'h0);
      clear_redirects();
      check("t4_pc", pc_out, 32'h0040_0004);
      check("t4_epc", epc_out, 32'h0040_0020);
      check("t4_epcwe", {31'd0, epc_we}, 32'd1);
      check("t4_mis", {31'd0, misalign}, 32'd1);
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      check("t4_epcwe_off", {31'd0, epc_we}, 32'd0);
      check("t4_mis_off", {31'd0, misalign}, 32'd0);
      check("t4_epc_hold", epc_out, 32'h0040_0020);
      // Exception beats an aligned jr
      exc = 1'b1; jr = 1'b1; jr_target = 32'h0040_0300;
      tick();
      clear_redirects();
      check("t4_exc_pc", pc_out, 32'h0040_0004);
      check("t4_exc_epc", epc_out, 32'h0040_0004);
      check("t4_exc_mis", {31'd0, misalign}, 32'd0);
      check("t4_exc_epcwe", {31'd0, epc_we}, 32'd1);

      // Wrap at the top of the address space, then halt beats exc
      jmp = 1'b1; jmp_target = 32'hFFFF_FFFC;
      fetch_exec(32'h0);
      clear_redirects();
      check("t6_top", pc_out, 32'hFFFF_FFFC);
      fetch_exec(32'h0);
      check("t6_wrap", pc_out, 32'h0000_0000);
      check("t6_wrap_we", {31'd0, pc_we}, 32'd1);
      halt = 1'b1; exc = 1'b1;
      fetch_exec(32'h0);
      clear_redirects();
      check("t6_halt_pc", pc_out, 32'h0000_0000);
      check("t6_halt_we", {31'd0, pc_we}, 32'd0);
      check("t6_halt_epcwe", {31'd0, epc_we}, 32'd0);
      check("t6_halt_epc", epc_out, 32'h0040_0004);
      imem_ack = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      imem_ack = 1'b0;
      check("t6_halt_req", {31'd0, imem_req}, 32'd0);
      check("t6_halt_valid", {31'd0, instr_valid}, 32'd0);
      check("t6_halt_hold", pc_out, 32'h0000_0000);

      // Reset mid-wait restarts the fetch counter
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("t5_mid_req", {31'd0, imem_req}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_rst_pc", pc_out, 32'h0040_0000);
      check("t5_rst_epc", epc_out, 32'd0);
      check("t5_rst_err", {31'd0, fetch_err}, 32'd0);
      for (int i = 0; i < 15; i++) tick();
      check("t5_req15", {31'd0, imem_req}, 32'd1);
      check("t5_err15", {31'd0, fetch_err}, 32'd0);
      tick();
      check("t5_err16", {31'd0, fetch_err}, 32'd1);
      check("t5_req16", {31'd0, imem_req}, 32'd0);
      imem_ack = 1'b1;
      tick();
      tick();
      imem_ack = 1'b0;
      check("t5_fault_hold", {31'd0, fetch_err}, 32'd1);
      check("t5_fault_valid", {31'd0, instr_valid}, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_clear_err", {31'd0, fetch_err}, 32'd0);
      check("t5_clear_req", {31'd0, imem_req}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Sequences the 32-bit program counter of the multicycle MIPS31 core.
- Issues an instruction-memory fetch for the current PC and waits for the memory acknowledge.
- Presents the fetched instruction to the core, then selects the next PC by priority: exception, jr, jump, branch, sequential.
- Produces the write-enable pulse for the architectural PC register and EPC capture; sits between the control unit, the instruction memory and the PC register.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0040_0004, exception handler entry address.
- FETCH_TIMEOUT, 16, maximum FETCH cycles without imem_ack before fault (range 2..255).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- imem_req  out  1  fetch request, high only in FETCH
- imem_addr  out  32  fetch address, equals pc_out
- imem_ack  in  1  instruction valid this cycle (sampled only in FETCH)
- imem_rdata  in  32  instruction word
- instr_valid  out  1  instr_out valid, high only in EXEC
- instr_out  out  32  latched instruction
- stall  in  1  core not ready, hold EXEC
- br_taken  in  1  conditional branch taken
- br_target  in  32  branch target
- jmp  in  1  j/jal
- jmp_target  in  32  jump target
- jr  in  1  jr/jalr
- jr_target  in  32  register target
- exc  in  1  exception raised by current instruction
- halt  in  1  break/stop, enter HALTED
- pc_out  out  32  current PC
- pc_we  out  1  one-cycle pulse when pc_out changes (drives PC register ena)
- epc_out  out  32  PC of faulting instruction
- epc_we  out  1  one-cycle pulse when epc_out captured
- fetch_err  out  1  sticky fetch-timeout flag
- misalign  out  1  one-cycle pulse, redirect target misaligned

Behaviour:
- Reset (rst=1 at edge), applied in any state including mid-fetch:
  - state=FETCH, pc_out=RESET_PC, instr_out=0, epc_out=0, wait counter=0.
  - All pulses and flags 0; fetch_err cleared.
- States:
  - FETCH: imem_req=1, imem_addr=pc_out.
    - imem_ack=1: latch imem_rdata into instr_out, clear counter, go to EXEC. Fetch latency is 1 cycle minimum.
    - imem_ack=0 and counter==FETCH_TIMEOUT-1: go to FAULT, set fetch_err.
    - Otherwise: increment counter.
  - EXEC: instr_valid=1, instr_out stable.
    - stall=1: remain in EXEC, no PC change, all other inputs ignored.
    - stall=0, halt=1: go to HALTED, PC unchanged, no pc_we.
    - stall=0, halt=0: compute next PC, pulse pc_we, go to FETCH. The new pc_out is visible the cycle FETCH is entered.
  - HALTED: outputs idle, pc_out held; exit only by rst.
  - FAULT: fetch_err=1, imem_req=0; exit only by rst.
- Next-PC priority in EXEC (first match wins):
  1. exc: next=EXEC_VECTOR, epc_out=pc_out, epc_we=1.
  2. jr: next=jr_target.
  3. jmp: next=jmp_target.
  4. br_taken: next=br_target.
  5. Otherwise: next=pc_out+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Alignment: if the selected redirect target (jr/jmp/br) has bits[1:0]!=0:
  - Treat as exception: next=EXEC_VECTOR, epc_out=pc_out, epc_we=1, misalign pulse=1.
  - EXEC_VECTOR is never checked.
- halt together with exc: halt wins, since it is checked first.
- imem_ack outside FETCH is ignored.
- All outputs are registered except imem_req, imem_addr and instr_valid, which decode from state/pc_out.

Decomposition:
- Package pc_seq_pkg:
  - state encoding: FETCH, EXEC, HALTED, FAULT (2-bit).
  - next-PC select codes: SEL_SEQ, SEL_BR, SEL_JMP, SEL_JR, SEL_EXC.
  - constant PC_STEP=4.
- One combinational sub-module pc_next_mux:
  - inputs: pc, the redirect flags and targets, EXEC_VECTOR.
  - outputs: next_pc, take_exc, misalign.
- Top holds the FSM, counter and registers.

Test Plan:
1. Reset then imem_ack=1 in first FETCH cycle, stall=0, no redirects -> pc_out 0x00400000 then 0x00400004 and 0x00400008 over successive 2-cycle loops; pc_we pulses every second cycle.
2. imem_ack delayed 3 cycles with stall=1 for 2 EXEC cycles -> imem_req high 4 cycles; instr_valid high 3 cycles; exactly one pc_we; instr_out equals the acknowledged word throughout.
3. In EXEC at pc 0x00400010 with br_taken=1 (0x00400100), jmp=1 (0x00400200), jr=1 (0x00400300) -> pc_out=0x00400300. Repeat with jr=0 -> pc_out=0x00400200.
4. jmp_target=0x00400102 at pc 0x00400020 -> pc_out=0x00400004, epc_out=0x00400020, epc_we=1 and misalign=1 for one cycle.
5. imem_ack held 0 with FETCH_TIMEOUT=16 -> fetch_err rises after 16 FETCH cycles and imem_req drops; rst=1 mid-wait (cycle 8) instead -> pc_out=RESET_PC, counter restarts, fetch_err stays 0.
6. pc_out=0xFFFFFFFC sequential step -> pc_out=0x00000000. halt=1 with exc=1 -> HALTED, pc unchanged, no epc_we; remains until rst.
